// File: rtl/apb_uart_fifo_if.sv
// APB slave port bundle for the buffered UART.
// The bus master drives control/address/write data; the UART answers with read data and status.
interface apb_uart_fifo_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_uart_fifo.sv
// APB-attached UART with TX/RX FIFOs, programmable divisor, optional parity and loopback.
// Zero-wait-state register slave; the serial pins are driven directly from the shifters.
module apb_uart_fifo #(
  parameter int          DATA_W     = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RST    = 16'd433
) (
  input  logic           PCLK,
  input  logic           PRESET,
  apb_uart_fifo_if.slave apb,
  output logic           txd,
  input  logic           rxd,
  output logic           irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_CHK, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  logic [6:0]  ctrl_reg;
  logic [15:0] div_reg;
  logic        ovr_reg, perr_reg, ferr_reg, irq_reg;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]       tx_wr_reg, tx_rd_reg, rx_wr_reg, rx_rd_reg;

  tx_state_t         tx_state_reg;
  logic [15:0]       tx_cnt_reg, tx_div_reg;
  logic [BW-1:0]     tx_bit_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic              tx_par_reg, tx_line_reg;

  rx_state_t         rx_state_reg;
  logic [15:0]       rx_cnt_reg, rx_div_reg;
  logic [BW-1:0]     rx_bit_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic              rx_s1_reg, rx_s2_reg, rx_prev_reg, rx_perr_reg, rx_push_reg;

  logic tx_en, rx_en, loopback, par_en, par_odd, irq_rx_en, irq_tx_en;
  assign tx_en     = ctrl_reg[0];
  assign rx_en     = ctrl_reg[1];
  assign loopback  = ctrl_reg[2];
  assign par_en    = ctrl_reg[3];
  assign par_odd   = ctrl_reg[4];
  assign irq_rx_en = ctrl_reg[5];
  assign irq_tx_en = ctrl_reg[6];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic tx_full, tx_empty, rx_full, rx_empty, tx_busy;
  assign tx_empty = (tx_wr_reg == tx_rd_reg);
  assign rx_empty = (rx_wr_reg == rx_rd_reg);
  assign tx_full  = (tx_wr_reg[AW] != tx_rd_reg[AW]) && (tx_wr_reg[AW-1:0] == tx_rd_reg[AW-1:0]);
  assign rx_full  = (rx_wr_reg[AW] != rx_rd_reg[AW]) && (rx_wr_reg[AW-1:0] == rx_rd_reg[AW-1:0]);
  assign tx_busy  = (tx_state_reg != TX_IDLE);

  logic apb_access, reg_wr, reg_rd;
  logic sel_data, sel_ctrl, sel_stat, sel_dlo, sel_dhi, mapped;
  assign apb_access = apb.PSEL & apb.PENABLE;
  assign reg_wr     = apb_access & apb.PWRITE;
  assign reg_rd     = apb_access & ~apb.PWRITE;
  assign sel_data   = (apb.PADDR == 8'h00);
  assign sel_ctrl   = (apb.PADDR == 8'h04);
  assign sel_stat   = (apb.PADDR == 8'h08);
  assign sel_dlo    = (apb.PADDR == 8'h0C);
  assign sel_dhi    = (apb.PADDR == 8'h10);
  assign mapped     = sel_data | sel_ctrl | sel_stat | sel_dlo | sel_dhi;

  // Full is evaluated before any shifter pop in the same cycle.
  logic tx_push, rx_pop;
  assign tx_push = reg_wr & sel_data & ~tx_full;
  assign rx_pop  = reg_rd & sel_data & ~rx_empty;

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = apb_access & ((sel_data & apb.PWRITE & tx_full) |
                                     (sel_data & ~apb.PWRITE & rx_empty) | ~mapped);

  logic [DATA_W-1:0] tx_head, rx_head;
  logic [7:0]        rx_head8;
  assign tx_head = tx_mem[tx_rd_reg[AW-1:0]];
  assign rx_head = rx_mem[rx_rd_reg[AW-1:0]];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_head
      if (gi < DATA_W) begin : g_bit
        assign rx_head8[gi] = rx_head[gi];
      end else begin : g_pad
        assign rx_head8[gi] = 1'b0;
      end
    end
  endgenerate

  logic [7:0] status_byte, rd_mux;
  assign status_byte = {tx_busy, ferr_reg, perr_reg, ovr_reg, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    rd_mux = 8'h00;
    case (apb.PADDR)
      8'h00:   rd_mux = rx_head8;
      8'h04:   rd_mux = {1'b0, ctrl_reg};
      8'h08:   rd_mux = status_byte;
      8'h0C:   rd_mux = div_reg[7:0];
      8'h10:   rd_mux = div_reg[15:8];
      default: rd_mux = 8'h00;
    endcase
    apb.PRDATA = (reg_rd & ~apb.PSLVERR) ? rd_mux : 8'h00;
  end

  logic tx_bit_end, tx_load;
  assign tx_bit_end = (tx_cnt_reg == tx_div_reg);
  assign tx_load    = tx_en & ~tx_empty &
                      ((tx_state_reg == TX_IDLE) | ((tx_state_reg == TX_STOP) & tx_bit_end));

  logic [16:0] rx_half;
  logic        rx_chk_hit, rx_bit_end, rx_fall, stop_sample;
  logic        frm_evt, par_evt, ovr_evt, rx_do_push;
  assign rx_half     = ({1'b0, rx_div_reg} + 17'd1) >> 1;
  assign rx_chk_hit  = (({1'b0, rx_cnt_reg} + 17'd1) >= rx_half);
  assign rx_bit_end  = (rx_cnt_reg == rx_div_reg);
  assign rx_fall     = rx_prev_reg & ~rx_s2_reg;
  assign stop_sample = (rx_state_reg == RX_STOP) & rx_bit_end;
  assign frm_evt     = stop_sample & ~rx_s2_reg;
  assign par_evt     = stop_sample & rx_perr_reg;
  // A concurrent APB pop frees the slot, so a full FIFO still accepts the byte.
  assign rx_do_push  = rx_push_reg & (~rx_full | rx_pop);
  assign ovr_evt     = rx_push_reg & rx_full & ~rx_pop;

  logic [2:0] w1c;
  assign w1c = (reg_wr & sel_stat) ? apb.PWDATA[6:4] : 3'b000;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_reg <= '0;
      div_reg  <= DIV_RST;
      ovr_reg  <= 1'b0;
      perr_reg <= 1'b0;
      ferr_reg <= 1'b0;
      irq_reg  <= 1'b0;
    end else begin
      if (reg_wr & sel_ctrl) ctrl_reg       <= apb.PWDATA[6:0];
      if (reg_wr & sel_dlo)  div_reg[7:0]   <= apb.PWDATA;
      if (reg_wr & sel_dhi)  div_reg[15:8]  <= apb.PWDATA;
      // New error events take priority over a same-cycle clear.
      ovr_reg  <= (ovr_reg  & ~w1c[0]) | ovr_evt;
      perr_reg <= (perr_reg & ~w1c[1]) | par_evt;
      ferr_reg <= (ferr_reg & ~w1c[2]) | frm_evt;
      irq_reg  <= (irq_rx_en & ~rx_empty) | (irq_tx_en & tx_empty & ~tx_busy) |
                  ovr_reg | perr_reg | ferr_reg;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_wr_reg <= '0;
      tx_rd_reg <= '0;
      rx_wr_reg <= '0;
      rx_rd_reg <= '0;
    end else begin
      if (tx_push)    tx_wr_reg <= tx_wr_reg + 1'b1;
      if (tx_load)    tx_rd_reg <= tx_rd_reg + 1'b1;
      if (rx_do_push) rx_wr_reg <= rx_wr_reg + 1'b1;
      if (rx_pop)     rx_rd_reg <= rx_rd_reg + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (tx_push)    tx_mem[tx_wr_reg[AW-1:0]] <= apb.PWDATA[DATA_W-1:0];
    if (rx_do_push) rx_mem[rx_wr_reg[AW-1:0]] <= rx_shift_reg;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_div_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_line_reg  <= 1'b1;
    end else if (tx_load) begin
      tx_state_reg <= TX_START;
      tx_cnt_reg   <= '0;
      tx_div_reg   <= div_reg;
      tx_shift_reg <= tx_head;
      tx_par_reg   <= (^tx_head) ^ par_odd;
      tx_line_reg  <= 1'b0;
    end else if (tx_state_reg != TX_IDLE) begin
      if (!tx_bit_end) begin
        tx_cnt_reg <= tx_cnt_reg + 16'd1;
      end else begin
        tx_cnt_reg <= '0;
        case (tx_state_reg)
          TX_START: begin
            tx_state_reg <= TX_DATA;
            tx_bit_reg   <= '0;
            tx_line_reg  <= tx_shift_reg[0];
          end
          TX_DATA: begin
            if (tx_bit_reg == LAST_BIT) begin
              tx_state_reg <= par_en ? TX_PAR : TX_STOP;
              tx_line_reg  <= par_en ? tx_par_reg : 1'b1;
            end else begin
              tx_bit_reg   <= tx_bit_reg + 1'b1;
              tx_shift_reg <= tx_shift_reg >> 1;
              tx_line_reg  <= tx_shift_reg[1];
            end
          end
          TX_PAR: begin
            tx_state_reg <= TX_STOP;
            tx_line_reg  <= 1'b1;
          end
          default: begin
            tx_state_reg <= TX_IDLE;
            tx_line_reg  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign txd = tx_line_reg | loopback;
  assign irq = irq_reg;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_s1_reg    <= 1'b1;
      rx_s2_reg    <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_div_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_perr_reg  <= 1'b0;
      rx_push_reg  <= 1'b0;
    end else begin
      rx_s1_reg   <= loopback ? tx_line_reg : rxd;
      rx_s2_reg   <= rx_s1_reg;
      rx_prev_reg <= rx_s2_reg;
      rx_push_reg <= stop_sample & rx_s2_reg;
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_en & rx_fall) begin
            rx_state_reg <= RX_CHK;
            rx_cnt_reg   <= '0;
            rx_div_reg   <= div_reg;
          end
        end
        RX_CHK: begin
          if (rx_chk_hit) begin
            rx_state_reg <= rx_s2_reg ? RX_IDLE : RX_DATA;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_perr_reg  <= 1'b0;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        default: begin
          if (!rx_bit_end) begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end else begin
            rx_cnt_reg <= '0;
            if (rx_state_reg == RX_DATA) begin
              rx_shift_reg <= {rx_s2_reg, rx_shift_reg[DATA_W-1:1]};
              if (rx_bit_reg == LAST_BIT) rx_state_reg <= par_en ? RX_PAR : RX_STOP;
              else                        rx_bit_reg   <= rx_bit_reg + 1'b1;
            end else if (rx_state_reg == RX_PAR) begin
              rx_perr_reg  <= rx_s2_reg ^ (^rx_shift_reg) ^ par_odd;
              rx_state_reg <= RX_STOP;
            end else begin
              rx_state_reg <= RX_IDLE;
            end
          end
        end
      endcase
    end
  end
endmodule
